jtag_ni_xfer_ctrl: RTL and testbench

JTAG_NI_XFER_CTRL -- requirements
Module: jtag_ni_xfer_ctrl

---
 rtl/jtag_ni_pkg.sv | 34 +++
 rtl/jtag_ni_xfer_ctrl_if.sv | 29 ++
 rtl/jtag_start_sync.sv | 40 ++++
 rtl/jtag_ni_xfer_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_jtag_ni_xfer_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_ni_pkg.sv
// Shared definitions for the JTAG-to-NI transfer controller.
// Holds the NI register map, the FSM encoding and the error codes.
package jtag_ni_pkg;

  localparam logic [2:0] NI_OFS_STATUS   = 3'd0;
  localparam logic [2:0] NI_OFS_SIZE     = 3'd3;
  localparam logic [2:0] NI_OFS_RECV_PTR = 3'd4;
  localparam logic [2:0] NI_OFS_SEND_PTR = 3'd5;
  localparam int unsigned NI_BUSY_BIT    = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_SIZE = 3'd1,
    ST_WR_PTR  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_POLL    = 3'd4
  } xfer_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BUS     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } xfer_err_e;

  function automatic logic is_bus_state(input xfer_state_e st);
    logic r;
    case (st)
      ST_WR_SIZE, ST_WR_PTR, ST_POLL: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jtag_ni_xfer_ctrl_if.sv
// Wishbone master bundle between the transfer controller and the NI.
interface jtag_ni_xfer_ctrl_if #(
  parameter int Dw   = 32,
  parameter int M_Aw = 32,
  parameter int TAGw = 3,
  parameter int SELw = 4
);
  logic [SELw-1:0] m_sel_o;
  logic [Dw-1:0]   m_dat_o;
  logic [M_Aw-1:0] m_addr_o;
  logic [TAGw-1:0] m_tag_o;
  logic            m_stb_o;
  logic            m_cyc_o;
  logic            m_we_o;
  logic [Dw-1:0]   m_dat_i;
  logic            m_ack_i;
  logic            m_err_i;
  logic            m_rty_i;

  modport master (
    output m_sel_o, m_dat_o, m_addr_o, m_tag_o, m_stb_o, m_cyc_o, m_we_o,
    input  m_dat_i, m_ack_i, m_err_i, m_rty_i
  );

  modport slave (
    input  m_sel_o, m_dat_o, m_addr_o, m_tag_o, m_stb_o, m_cyc_o, m_we_o,
    output m_dat_i, m_ack_i, m_err_i, m_rty_i
  );
endinterface

// File: rtl/jtag_start_sync.sv
// Brings the JTAG-domain start line into clk and emits a registered
// one-cycle pulse on its falling edge.
module jtag_start_sync (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic start_fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  // Synchroniser chain and edge detection.
  always_comb begin
    meta_d = start_i;
    sync_d = meta_q;
    prev_d = sync_q;
    fall_d = prev_q & ~sync_q;
  end

  // Chain resets high so an idle-high line never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign start_fall_o = fall_q;

endmodule

// File: rtl/jtag_ni_xfer_ctrl.sv
// Programs the NI with packet size and buffer pointer over Wishbone, then
// polls the NI status until idle, timeout or bus error.
module jtag_ni_xfer_ctrl
  import jtag_ni_pkg::*;
#(
  parameter logic [31:0] NI_BASE_ADDR = 32'h0,
  parameter int Dw        = 32,
  parameter int M_Aw      = 32,
  parameter int TAGw      = 3,
  parameter int SELw      = 4,
  parameter int PCKw      = 9,
  parameter int POLL_WAIT = 8,
  parameter int TIMEOUT   = 1023,
  localparam int TOw      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [PCKw-1:0]  pck_size_i,
  input  logic [M_Aw-1:0]  mem_ptr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_code_o,
  output logic [TOw-1:0]   poll_cnt_o,
  jtag_ni_xfer_ctrl_if.master wb
);

  localparam logic [7:0]      WAIT_LAST = 8'(POLL_WAIT - 1);
  localparam logic [TOw-1:0]  TO_LIMIT  = TOw'(TIMEOUT);
  localparam logic [M_Aw-1:0] BASE      = M_Aw'(NI_BASE_ADDR);

  xfer_state_e     state_q, state_d;
  logic            gap_q, gap_d;
  logic [7:0]      wait_q, wait_d;
  logic            done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [TOw-1:0]  poll_q, poll_d;
  logic            dir_q, dir_d;
  logic [PCKw-1:0] size_q, size_d;
  logic [M_Aw-1:0] ptr_q, ptr_d;

  logic            start_fall;
  logic            bus_live;
  logic            rsp_ack, rsp_err, rsp_rty;
  logic [PCKw:0]   size_p1;
  logic [TOw-1:0]  poll_inc;
  logic            unused_dat_s;

  jtag_start_sync u_start_sync (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .start_fall_o (start_fall)
  );

  assign unused_dat_s = ^wb.m_dat_i;

  // Bus outputs decoded from state and snapshot registers only.
  always_comb begin
    size_p1     = {1'b0, size_q} + {{PCKw{1'b0}}, 1'b1};
    bus_live    = is_bus_state(state_q) && !gap_q;
    wb.m_sel_o  = '0;
    wb.m_dat_o  = '0;
    wb.m_addr_o = BASE + M_Aw'(NI_OFS_STATUS);
    wb.m_tag_o  = '0;
    wb.m_we_o   = 1'b0;
    case (state_q)
      ST_WR_SIZE: begin
        wb.m_addr_o = BASE + M_Aw'(NI_OFS_SIZE);
        wb.m_dat_o  = Dw'(size_p1);
        wb.m_we_o   = 1'b1;
        wb.m_sel_o  = '1;
      end
      ST_WR_PTR: begin
        if (dir_q) begin
          wb.m_addr_o = BASE + M_Aw'(NI_OFS_RECV_PTR);
        end else begin
          wb.m_addr_o = BASE + M_Aw'(NI_OFS_SEND_PTR);
        end
        wb.m_dat_o = Dw'({ptr_q[M_Aw-3:0], 2'b00});
        wb.m_we_o  = 1'b1;
        wb.m_sel_o = '1;
      end
      ST_POLL: begin
        wb.m_sel_o = '1;
      end
      default: begin
        wb.m_sel_o = '0;
      end
    endcase
    wb.m_stb_o = bus_live;
    wb.m_cyc_o = bus_live;
  end

  // Responses only count while the strobe is actually out; err beats ack beats rty.
  always_comb begin
    rsp_err  = bus_live && wb.m_err_i;
    rsp_ack  = bus_live && !wb.m_err_i && wb.m_ack_i;
    rsp_rty  = bus_live && !wb.m_err_i && !wb.m_ack_i && wb.m_rty_i;
    poll_inc = poll_q + TOw'(1'b1);
  end

  // Transfer sequencing.
  always_comb begin
    state_d = state_q;
    gap_d   = 1'b0;
    wait_d  = wait_q;
    done_d  = 1'b0;
    err_d   = err_q;
    poll_d  = poll_q;
    dir_d   = dir_q;
    size_d  = size_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_fall) begin
          dir_d   = dir_i;
          size_d  = pck_size_i;
          ptr_d   = mem_ptr_i;
          err_d   = ERR_NONE;
          poll_d  = '0;
          state_d = ST_WR_SIZE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = 8'd0;
          state_d = ST_POLL;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WR_SIZE, ST_WR_PTR, ST_POLL: begin
        if (rsp_err) begin
          err_d   = ERR_BUS;
          state_d = ST_IDLE;
        end else if (rsp_ack) begin
          case (state_q)
            ST_WR_SIZE: state_d = ST_WR_PTR;
            ST_WR_PTR: begin
              wait_d  = 8'd0;
              state_d = ST_WAIT;
            end
            ST_POLL: begin
              if (!wb.m_dat_i[NI_BUSY_BIT]) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else if (poll_inc == TO_LIMIT) begin
                poll_d  = poll_inc;
                err_d   = ERR_TIMEOUT;
                state_d = ST_IDLE;
              end else begin
                poll_d  = poll_inc;
                wait_d  = 8'd0;
                state_d = ST_WAIT;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else if (rsp_rty) begin
          gap_d = 1'b1;
        end else begin
          gap_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and transfer context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= 1'b0;
      wait_q  <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= ERR_NONE;
      poll_q  <= '0;
      dir_q   <= 1'b0;
      size_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
      dir_q   <= dir_d;
      size_q  <= size_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign err_code_o = err_q;
  assign poll_cnt_o = poll_q;

endmodule

// File: tb/tb_jtag_ni_xfer_ctrl.sv
// Scoreboard bench: expected NI bus transactions are queued per transfer and
// compared by a responding NI model as the controller issues them.
module tb_jtag_ni_xfer_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TAGW = 3;
  localparam int SELW = 4;
  localparam int PCKW = 9;
  localparam int PW   = 3;
  localparam int TO   = 4;
  localparam int TOW  = $clog2(TO + 1);
  localparam logic [31:0] BASE = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
    logic        we;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_i;
  logic            dir_i;
  logic [PCKW-1:0] pck_size_i;
  logic [AW-1:0]   mem_ptr_i;
  logic            busy_o;
  logic            done_o;
  logic [1:0]      err_code_o;
  logic [TOW-1:0]  poll_cnt_o;

  jtag_ni_xfer_ctrl_if #(.Dw(DW), .M_Aw(AW), .TAGw(TAGW), .SELw(SELW)) wb_if ();

  jtag_ni_xfer_ctrl #(
    .NI_BASE_ADDR(BASE), .Dw(DW), .M_Aw(AW), .TAGw(TAGW), .SELw(SELW),
    .PCKw(PCKW), .POLL_WAIT(PW), .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .dir_i      (dir_i),
    .pck_size_i (pck_size_i),
    .mem_ptr_i  (mem_ptr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_code_o (err_code_o),
    .poll_cnt_o (poll_cnt_o),
    .wb         (wb_if)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   cyc_n = 0;
  int   last_stb = 0;
  int   done_cnt = 0;
  int   unexp_cnt = 0;
  int   busy_left = 0;
  logic rty_size_once = 1'b0;
  logic err_ptr = 1'b0;
  logic rty_prev = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // NI model: compares each strobed cycle against the scoreboard and responds.
  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (rty_prev) check_val("rty_gap_stb", 64'(wb_if.m_stb_o), 64'd0);
    rty_prev = 1'b0;
    wb_if.m_ack_i = 1'b0;
    wb_if.m_err_i = 1'b0;
    wb_if.m_rty_i = 1'b0;
    wb_if.m_dat_i = 32'hFFFF_FFFE;
    if (done_o === 1'b1) done_cnt++;
    if (reset === 1'b0 && wb_if.m_stb_o === 1'b1 && wb_if.m_cyc_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        unexp_cnt++;
      end else begin
        e = exp_q.pop_front();
        check_val("txn_addr", 64'(wb_if.m_addr_o), 64'(e.addr));
        check_val("txn_we", 64'(wb_if.m_we_o), 64'(e.we));
        if (e.we) check_val("txn_dat", 64'(wb_if.m_dat_o), 64'(e.dat));
        check_val("txn_sel", 64'(wb_if.m_sel_o), 64'h0F);
        check_val("txn_tag", 64'(wb_if.m_tag_o), 64'd0);
      end
      if (wb_if.m_we_o && wb_if.m_addr_o == BASE + 32'd3 && rty_size_once) begin
        wb_if.m_rty_i = 1'b1;
        rty_size_once = 1'b0;
        rty_prev = 1'b1;
      end else if (wb_if.m_we_o && wb_if.m_addr_o != BASE + 32'd3 && err_ptr) begin
        wb_if.m_err_i = 1'b1;
        err_ptr = 1'b0;
      end else begin
        wb_if.m_ack_i = 1'b1;
        if (!wb_if.m_we_o) begin
          check_val("poll_wait", 64'(cyc_n - last_stb), 64'(PW + 1));
          if (busy_left != 0) begin
            wb_if.m_dat_i[0] = 1'b1;
            if (busy_left > 0) busy_left--;
          end
        end
      end
      last_stb = cyc_n;
    end
  end

  task automatic push_xfer(input logic d, input logic [PCKW-1:0] sz, input logic [31:0] p,
                           input int npolls, input logic dup_size);
    exp_t e;
    e.we = 1'b1; e.addr = BASE + 32'd3; e.dat = 32'(sz) + 32'd1;
    exp_q.push_back(e);
    if (dup_size) exp_q.push_back(e);
    e.addr = BASE + (d ? 32'd4 : 32'd5); e.dat = p * 32'd4;
    exp_q.push_back(e);
    for (int i = 0; i < npolls; i++) begin
      e.we = 1'b0; e.addr = BASE; e.dat = 32'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_xfer(input logic d, input logic [PCKW-1:0] sz, input logic [31:0] p);
    @(negedge clk);
    dir_i = d; pck_size_i = sz; mem_ptr_i = p; start_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("start_lat_early", 64'(busy_o), 64'd0);
    @(negedge clk);
    check_val("start_lat", 64'(busy_o), 64'd1);
    start_i = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_idle"}, 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk);
    check_val({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_unexp"}, 64'(unexp_cnt), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b1; dir_i = 1'b0; pck_size_i = '0; mem_ptr_i = '0;
    wb_if.m_ack_i = 1'b0; wb_if.m_err_i = 1'b0; wb_if.m_rty_i = 1'b0; wb_if.m_dat_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 64'(busy_o), 64'd0);
    check_val("rst_done", 64'(done_o), 64'd0);
    check_val("rst_err", 64'(err_code_o), 64'd0);
    check_val("rst_poll", 64'(poll_cnt_o), 64'd0);
    check_val("rst_stb", 64'({wb_if.m_stb_o, wb_if.m_cyc_o}), 64'd0);
    check_val("rst_addr", 64'(wb_if.m_addr_o), 64'(BASE));
    check_val("rst_dat", 64'(wb_if.m_dat_o), 64'd0);

    // Send with two busy polls.
    done_cnt = 0; busy_left = 2;
    push_xfer(1'b0, 9'd5, 32'h40, 3, 1'b0);
    start_xfer(1'b0, 9'd5, 32'h40);
    wait_idle("send");
    check_val("send_done", 64'(done_cnt), 64'd1);
    check_val("send_poll", 64'(poll_cnt_o), 64'd2);
    check_val("send_err", 64'(err_code_o), 64'd0);

    // Receive, maximum size, inputs change after acceptance.
    done_cnt = 0; busy_left = 0;
    push_xfer(1'b1, 9'h1FF, 32'h1, 1, 1'b0);
    start_xfer(1'b1, 9'h1FF, 32'h1);
    dir_i = 1'b0; pck_size_i = 9'd7; mem_ptr_i = 32'h55;
    wait_idle("recv");
    check_val("recv_done", 64'(done_cnt), 64'd1);
    check_val("recv_poll", 64'(poll_cnt_o), 64'd0);

    // Timeout: NI never goes idle.
    done_cnt = 0; busy_left = -1;
    push_xfer(1'b0, 9'd0, 32'h3FFF_FFFF, TO, 1'b0);
    start_xfer(1'b0, 9'd0, 32'h3FFF_FFFF);
    wait_idle("tmo");
    check_val("tmo_err", 64'(err_code_o), 64'd2);
    check_val("tmo_poll", 64'(poll_cnt_o), 64'(TO));
    check_val("tmo_done", 64'(done_cnt), 64'd0);

    // Bus error on the pointer write, then a clean transfer.
    done_cnt = 0; busy_left = 0; err_ptr = 1'b1;
    push_xfer(1'b0, 9'd2, 32'h10, 0, 1'b0);
    start_xfer(1'b0, 9'd2, 32'h10);
    check_val("berr_poll_clr", 64'(poll_cnt_o), 64'd0);
    wait_idle("berr");
    check_val("berr_err", 64'(err_code_o), 64'd1);
    check_val("berr_done", 64'(done_cnt), 64'd0);
    push_xfer(1'b1, 9'd3, 32'h20, 1, 1'b0);
    start_xfer(1'b1, 9'd3, 32'h20);
    check_val("berr_clr", 64'(err_code_o), 64'd0);
    wait_idle("after_berr");
    check_val("after_berr_done", 64'(done_cnt), 64'd1);

    // Retry on size write, plus a start edge while busy.
    done_cnt = 0; busy_left = 1; rty_size_once = 1'b1;
    push_xfer(1'b0, 9'd9, 32'h80, 2, 1'b1);
    start_xfer(1'b0, 9'd9, 32'h80);
    @(negedge clk); start_i = 1'b0;
    repeat (3) @(negedge clk); start_i = 1'b1;
    wait_idle("rty");
    check_val("rty_done", 64'(done_cnt), 64'd1);
    repeat (8) @(negedge clk);
    check_val("ign_start", 64'(busy_o), 64'd0);

    // Reset in the middle of a poll.
    done_cnt = 0; busy_left = -1;
    push_xfer(1'b0, 9'd1, 32'h4, 1, 1'b0);
    start_xfer(1'b0, 9'd1, 32'h4);
    begin
      int n = 0;
      while (n < 100 && !(wb_if.m_stb_o === 1'b1 && wb_if.m_we_o === 1'b0)) begin
        @(negedge clk); #1; n++;
      end
      check_val("rst_mid_poll_seen", 64'(wb_if.m_stb_o), 64'd1);
    end
    reset = 1'b1;
    #1;
    check_val("rst_mid_stb", 64'({wb_if.m_stb_o, wb_if.m_cyc_o}), 64'd0);
    check_val("rst_mid_busy", 64'(busy_o), 64'd0);
    check_val("rst_mid_err", 64'(err_code_o), 64'd0);
    check_val("rst_mid_poll", 64'(poll_cnt_o), 64'd0);
    check_val("rst_mid_done", 64'(done_o), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_mid_quiet", 64'(busy_o), 64'd0);
    check_val("rst_mid_left", 64'(exp_q.size()), 64'd0);
    check_val("rst_mid_unexp", 64'(unexp_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
